// File: rtl/program_sequencer.sv
// Program address sequencer: SEQ/JMP/BR/BRIF/CALL/RET with a return-address
// stack and sticky overflow/underflow flags; state advances on falling edge.
module program_sequencer #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              advance,
  input  logic [2:0]        op,
  input  logic              cond,
  input  logic [DATA_W-1:0] data_bus,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] addr,
  output logic [SP_W-1:0]   sp,
  output logic              stack_full,
  output logic              overflow,
  output logic              underflow
);

  if (ADDR_W > DATA_W) begin : g_bad_addr_w
    $fatal(1, "program_sequencer: ADDR_W must be <= DATA_W");
  end
  if (STACK_DEPTH < 1) begin : g_bad_depth
    $fatal(1, "program_sequencer: STACK_DEPTH must be >= 1");
  end

  logic [ADDR_W-1:0] stack [STACK_DEPTH];

  logic [ADDR_W-1:0] inc;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] rel;
  logic [ADDR_W-1:0] top;
  logic [ADDR_W-1:0] addr_n;
  logic [SP_W-1:0]   sp_n;
  logic              push;
  logic              ovf_n;
  logic              udf_n;
  logic              unused_bits;

  // Only the low ADDR_W bits of the bus carry a target.
  assign unused_bits = ^data_bus;
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));

  always_comb begin
    inc = addr + 1'b1;
    tgt = data_bus[ADDR_W-1:0];
    rel = inc + tgt;
    top = stack[0];
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp == SP_W'(i + 1)) top = stack[i];
    end
  end

  always_comb begin
    addr_n = addr;
    sp_n   = sp;
    push   = 1'b0;
    ovf_n  = err_clr ? 1'b0 : overflow;
    udf_n  = err_clr ? 1'b0 : underflow;
    if (advance) begin
      unique case (op)
        3'b000: addr_n = inc;
        3'b001: addr_n = tgt;
        3'b010: addr_n = rel;
        3'b011: addr_n = cond ? rel : inc;
        3'b100: begin
          if (stack_full) begin
            ovf_n = 1'b1;
          end else begin
            push   = 1'b1;
            sp_n   = sp + 1'b1;
            addr_n = tgt;
          end
        end
        3'b101: begin
          if (sp == '0) begin
            udf_n = 1'b1;
          end else begin
            addr_n = top;
            sp_n   = sp - 1'b1;
          end
        end
        3'b110: addr_n = addr;
        3'b111: addr_n = inc;
      endcase
    end
  end

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr      <= ADDR_W'(RESET_ADDR);
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      addr      <= addr_n;
      sp        <= sp_n;
      overflow  <= ovf_n;
      underflow <= udf_n;
    end
  end

  // Contents are meaningless above sp, so the array needs no reset.
  always_ff @(negedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (push && sp == SP_W'(i)) stack[i] <= inc;
    end
  end

endmodule
